// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
//
// Free-running VGA raster timing generator (640x480 @ 60 Hz by default,
// 25 MHz pixel clock). Produces the pixel coordinates and display_area for
// the colour stage. hsync/vsync are delayed one clock so they line up with
// the colour stage's registered RGB. A one-clock vblank_start tick marks
// the first clock of vertical blanking.
//
// Ports:
//   clock_25      in   pixel clock
//   reset_n       in   asynchronous reset, active low
//   pixel_x       out  horizontal count, 0..H_TOTAL-1
//   pixel_y       out  line count, 0..V_TOTAL-1
//   display_area  out  high inside the visible window, aligned with pixel_x/y
//   hsync         out  horizontal sync, one clock behind pixel_x
//   vsync         out  vertical sync, one clock behind pixel_x/pixel_y
//   vblank_start  out  one-clock pulse at (0, V_VISIBLE)
// ---------------------------------------------------------------------------
module vga_sync_generator #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clock_25,
  input  logic       reset_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       display_area,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 10-bit copies of the timing boundaries so every compare is width-matched.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       h_win;
  logic       v_win;

  always_comb begin
    x_next = pixel_x + 10'd1;
    y_next = pixel_y;
    if (pixel_x == H_LAST) begin
      x_next = '0;
      if (pixel_y == V_LAST) begin
        y_next = '0;
      end else begin
        y_next = pixel_y + 10'd1;
      end
    end
  end

  // Sync windows decode the current counters; the register below adds the
  // one-clock lag that matches the colour pipeline.
  assign h_win = (pixel_x >= HS_START) && (pixel_x < HS_END);
  assign v_win = (pixel_y >= VS_START) && (pixel_y < VS_END);

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      // Parked on the last pixel so the first edge after release lands on (0,0).
      pixel_x      <= H_LAST;
      pixel_y      <= V_LAST;
      display_area <= 1'b0;
      hsync        <= ~SYNC_ACTIVE;
      vsync        <= ~SYNC_ACTIVE;
      vblank_start <= 1'b0;
    end else begin
      pixel_x      <= x_next;
      pixel_y      <= y_next;
      // Computed from next-state counters so it is aligned with pixel_x/y.
      display_area <= (x_next < H_VIS) && (y_next < V_VIS);
      vblank_start <= (x_next == 10'd0) && (y_next == V_VIS);
      hsync        <= h_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync        <= v_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  logic [9:0] ax, ay, bx, by;
  logic ada, ahs, avs, avb;
  logic bda, bhs, bvs, bvb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Default 640x480 timing, active-low sync.
  vga_sync_generator dut_a (
    .clock_25(clk), .reset_n(rst_a),
    .pixel_x(ax), .pixel_y(ay), .display_area(ada),
    .hsync(ahs), .vsync(avs), .vblank_start(avb)
  );

  // Tiny raster: H 8/2/3/2 (15), V 4/1/2/1 (8), active-high sync.
  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clock_25(clk), .reset_n(rst_b),
    .pixel_x(bx), .pixel_y(by), .display_area(bda),
    .hsync(bhs), .vsync(bvs), .vblank_start(bvb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int a_da_cnt, a_hs_cnt, a_vs_cnt, a_vb_cnt, a_hs_falls, a_first_hs_x, a_first_off_x;
    logic a_hs_seen, a_off_seen, a_hs_prev;
    int b_da_cnt, b_hs_cnt, b_vs_cnt, b_vb_cnt;
    int b_vb_idx[2];
    int b_first_hs_x, b_first_hs_y, b_first_vs_x, b_first_vs_y;
    logic b_hs_seen, b_vs_seen;
    int b_prev_x, b_prev_y;
    logic found;

    a_da_cnt = 0; a_hs_cnt = 0; a_vs_cnt = 0; a_vb_cnt = 0; a_hs_falls = 0;
    a_first_hs_x = -1; a_first_off_x = -1;
    a_hs_seen = 1'b0; a_off_seen = 1'b0; a_hs_prev = 1'b1;
    b_da_cnt = 0; b_hs_cnt = 0; b_vs_cnt = 0; b_vb_cnt = 0;
    b_vb_idx[0] = -1; b_vb_idx[1] = -1;
    b_first_hs_x = -1; b_first_hs_y = -1; b_first_vs_x = -1; b_first_vs_y = -1;
    b_hs_seen = 1'b0; b_vs_seen = 1'b0;
    b_prev_x = 0; b_prev_y = 0;

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);

    check("a_rst_x", ax, 799);
    check("a_rst_y", ay, 524);
    check("a_rst_da", ada, 0);
    check("a_rst_hs", ahs, 1);
    check("a_rst_vs", avs, 1);
    check("a_rst_vb", avb, 0);
    check("b_rst_x", bx, 14);
    check("b_rst_y", by, 7);
    check("b_rst_da", bda, 0);
    check("b_rst_hs", bhs, 0);
    check("b_rst_vs", bvs, 0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    check("a_first_x", ax, 0);
    check("a_first_y", ay, 0);
    check("a_first_da", ada, 1);
    check("a_first_hs", ahs, 1);
    check("a_first_vs", avs, 1);
    check("b_first_x", bx, 0);
    check("b_first_y", by, 0);
    check("b_first_da", bda, 1);
    check("b_first_hs", bhs, 0);

    // Sample 0 is the first clock after release. A runs one full line,
    // B runs two full frames (240 clocks) in the same window.
    for (int i = 0; i < 800; i++) begin
      if (ada) a_da_cnt++;
      if (!ada && !a_off_seen) begin
        a_off_seen = 1'b1;
        a_first_off_x = int'(ax);
      end
      if (!ahs) begin
        a_hs_cnt++;
        if (!a_hs_seen) begin
          a_hs_seen = 1'b1;
          a_first_hs_x = int'(ax);
        end
      end
      if (a_hs_prev && !ahs) a_hs_falls++;
      a_hs_prev = ahs;
      if (!avs) a_vs_cnt++;
      if (avb) a_vb_cnt++;

      if (i < 240) begin
        if (bda) b_da_cnt++;
        if (bhs) begin
          b_hs_cnt++;
          if (!b_hs_seen) begin
            b_hs_seen = 1'b1;
            b_first_hs_x = int'(bx);
            b_first_hs_y = int'(by);
          end
        end
        if (bvs) begin
          b_vs_cnt++;
          if (!b_vs_seen) begin
            b_vs_seen = 1'b1;
            b_first_vs_x = int'(bx);
            b_first_vs_y = int'(by);
          end
        end
        if (bvb) begin
          if (b_vb_cnt < 2) b_vb_idx[b_vb_cnt] = i;
          b_vb_cnt++;
          check("b_vb_x", bx, 0);
          check("b_vb_y", by, 4);
        end
        if (i > 0 && b_prev_x == 14 && b_prev_y == 7) begin
          check("b_wrap_x", bx, 0);
          check("b_wrap_y", by, 0);
          check("b_wrap_da", bda, 1);
        end
        if (b_prev_x == 14 && b_prev_y == 3) begin
          check("b_vis_end_x", bx, 0);
          check("b_vis_end_y", by, 4);
          check("b_vis_end_da", bda, 0);
        end
        b_prev_x = int'(bx);
        b_prev_y = int'(by);
      end
      @(negedge clk);
    end

    check("a_da_cnt", a_da_cnt, 640);
    check("a_da_off_x", a_first_off_x, 640);
    check("a_hs_cnt", a_hs_cnt, 96);
    check("a_hs_first_x", a_first_hs_x, 657);
    check("a_hs_falls", a_hs_falls, 1);
    check("a_vs_line0", a_vs_cnt, 0);
    check("a_vb_line0", a_vb_cnt, 0);
    check("a_line_x", ax, 0);
    check("a_line_y", ay, 1);

    check("b_da_cnt", b_da_cnt, 64);
    check("b_hs_cnt", b_hs_cnt, 48);
    check("b_hs_first_x", b_first_hs_x, 11);
    check("b_hs_first_y", b_first_hs_y, 0);
    check("b_vs_cnt", b_vs_cnt, 60);
    check("b_vs_first_x", b_first_vs_x, 1);
    check("b_vs_first_y", b_first_vs_y, 5);
    check("b_vb_cnt", b_vb_cnt, 2);
    check("b_vb_idx0", b_vb_idx[0], 60);
    check("b_vb_period", b_vb_idx[1] - b_vb_idx[0], 120);
    // 800 clocks = 6 frames + 80 clocks -> line 5, pixel 5.
    check("b_pos_x", bx, 5);
    check("b_pos_y", by, 5);

    // Mid-line reset of A while hsync is active.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (ax == 10'd700) found = 1'b1;
      else @(negedge clk);
    end
    check("a_reach_700", found, 1);
    check("a_pre_rst_hs", ahs, 0);
    #2 rst_a = 1'b0;
    #1;
    check("a_async_x", ax, 799);
    check("a_async_y", ay, 524);
    check("a_async_da", ada, 0);
    check("a_async_hs", ahs, 1);
    check("a_async_vs", avs, 1);
    check("a_async_vb", avb, 0);
    repeat (3) @(negedge clk);
    check("a_held_x", ax, 799);
    check("a_held_hs", ahs, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_restart_x", ax, 0);
    check("a_restart_y", ay, 0);
    check("a_restart_da", ada, 1);
    check("a_restart_hs", ahs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
